square_wave_generator: RTL and testbench

Tone generator for sound channel 1, directly downstream of the frequency sweep stage. Consumes the sweep-adjusted 11-bit frequency (NR13/NR14 shadow) and the sweep overflow enable. Produces a 1-bit duty-cycled square wave plus a channel-active flag. Implements the frequency timer, 8-step duty sequencer, 64-step length counter and trigger handling; the envelope/DAC stage consumes the output.

---
 rtl/sound_pkg.sv | 20 ++
 rtl/length_counter.sv | 48 ++++
 rtl/square_wave_generator.sv | 90 +++++++++
 tb/tb_square_wave_generator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared constants for the sound channel 1 square-wave path.
package sound_pkg;

  // Duty waveforms; bit n is the sample output at sequencer step n.
  localparam logic [7:0] DUTY_PATTERN [4] = '{
    8'b0000_0001,
    8'b1000_0001,
    8'b1000_0111,
    8'b0111_1110
  };

  localparam int unsigned LENGTH_MAX  = 64;
  localparam logic [10:0] PERIOD_WRAP = 11'h7FF;

  // Length counter start value for a 6-bit register load.
  function automatic logic [6:0] length_load(input logic [5:0] val);
    return 7'(LENGTH_MAX) - {1'b0, val};
  endfunction

endpackage

// File: rtl/length_counter.sv
// 64-step length counter: counts down on enabled length ticks and pulses
// expire_o on the tick that reaches zero.
module length_counter
  import sound_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_i,
  input  logic       length_tick_i,
  input  logic       length_en_i,
  input  logic [5:0] load_i,
  output logic       expire_o
);

  logic [6:0] cnt_q, cnt_d;
  logic [5:0] cmp_q;
  logic       dec_en;

  assign dec_en = length_tick_i & length_en_i & (cnt_q != '0);

  // Next count: trigger, then expiry, then register reload, then decrement.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (trigger_i) begin
      cnt_d = length_load(load_i);
    end else if (dec_en && (cnt_q == 7'd1)) begin
      cnt_d    = '0;
      expire_o = 1'b1;
    end else if (load_i != cmp_q) begin
      cnt_d = length_load(load_i);
    end else if (dec_en) begin
      cnt_d = cnt_q - 7'd1;
    end
  end

  // Count and register-compare state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= load_i;
    end
  end

endmodule

// File: rtl/square_wave_generator.sv
// Sound channel 1 tone generator: trigger detect, frequency timer,
// 8-step duty sequencer and channel-active flag.
module square_wave_generator
  import sound_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step_tick,
  input  logic       length_tick,
  input  logic [7:0] NR11,
  input  logic [7:0] NR14,
  input  logic [7:0] internal_NR13_reg,
  input  logic [7:0] internal_NR14_reg,
  input  logic       enable_square_wave,
  output logic       wave_out,
  output logic       channel_on
);

  logic [10:0] freq;
  logic [10:0] period_cnt_q, period_cnt_d;
  logic [2:0]  duty_pos_q, duty_pos_d;
  logic        channel_on_q, channel_on_d;
  logic        nr14_trig_q;
  logic        trig_armed_q;
  logic        trigger;
  logic        len_expire;
  logic        unused_bits;

  assign freq        = {internal_NR14_reg[2:0], internal_NR13_reg};
  assign unused_bits = ^{internal_NR14_reg[7:3], NR14[5:0]};

  // The armed flag keeps a trigger bit held high across reset release from
  // firing: the edge register samples it on the first edge before any trigger.
  assign trigger = trig_armed_q & NR14[7] & ~nr14_trig_q;

  length_counter u_len (
    .clock         (clock),
    .reset         (reset),
    .trigger_i     (trigger),
    .length_tick_i (length_tick),
    .length_en_i   (NR14[6]),
    .load_i        (NR11[5:0]),
    .expire_o      (len_expire)
  );

  // Next state for timer, sequencer and channel flag; trigger drops ticks.
  always_comb begin
    channel_on_d = channel_on_q;
    period_cnt_d = period_cnt_q;
    duty_pos_d   = duty_pos_q;
    if (trigger) begin
      channel_on_d = 1'b1;
      period_cnt_d = freq;
      duty_pos_d   = '0;
    end else begin
      if (!enable_square_wave || len_expire) begin
        channel_on_d = 1'b0;
      end
      if (step_tick) begin
        if (period_cnt_q == PERIOD_WRAP) begin
          period_cnt_d = freq;
          duty_pos_d   = duty_pos_q + 3'd1;
        end else begin
          period_cnt_d = period_cnt_q + 11'd1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      channel_on_q <= 1'b0;
      period_cnt_q <= '0;
      duty_pos_q   <= '0;
      nr14_trig_q  <= 1'b0;
      trig_armed_q <= 1'b0;
    end else begin
      channel_on_q <= channel_on_d;
      period_cnt_q <= period_cnt_d;
      duty_pos_q   <= duty_pos_d;
      nr14_trig_q  <= NR14[7];
      trig_armed_q <= 1'b1;
    end
  end

  assign channel_on = channel_on_q;
  assign wave_out   = channel_on_q & DUTY_PATTERN[NR11[7:6]][duty_pos_q];

endmodule

// File: tb/tb_square_wave_generator.sv
// Self-checking bench for square_wave_generator: directed scenarios followed
// by randomized bursts, all compared against a tick-counting reference model.
module tb_square_wave_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic       step_tick;
  logic       length_tick;
  logic [7:0] NR11;
  logic [7:0] NR14;
  logic [7:0] internal_NR13_reg;
  logic [7:0] internal_NR14_reg;
  logic       enable_square_wave;
  logic       wave_out;
  logic       channel_on;

  int total = 0;
  int bad   = 0;

  // Reference model: channel flag, step ticks since trigger, ticks per
  // sequencer step, length ticks remaining, trigger-edge bookkeeping.
  int   m_on, m_ticks, m_P, m_len, m_armed, m_prev7, m_prevL;
  int   pats [4][8] = '{'{1,0,0,0,0,0,0,0},
                        '{1,0,0,0,0,0,0,1},
                        '{1,1,1,0,0,0,0,1},
                        '{0,1,1,1,1,1,1,0}};
  int   seq10 [8] = '{1,1,1,0,0,0,0,1};

  square_wave_generator dut (
    .clock              (clock),
    .reset              (reset),
    .step_tick          (step_tick),
    .length_tick        (length_tick),
    .NR11               (NR11),
    .NR14               (NR14),
    .internal_NR13_reg  (internal_NR13_reg),
    .internal_NR14_reg  (internal_NR14_reg),
    .enable_square_wave (enable_square_wave),
    .wave_out           (wave_out),
    .channel_on         (channel_on)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_ticks = 0; m_P = 2048; m_len = 0;
    m_armed = 0; m_prev7 = 0; m_prevL = 0;
  endtask

  function automatic int exp_wave();
    if (m_on == 0) return 0;
    return pats[NR11[7:6]][(m_ticks / m_P) % 8];
  endfunction

  task automatic set_freq(input int f);
    internal_NR13_reg = f[7:0];
    internal_NR14_reg = {5'b10101, f[10:8]};
  endtask

  // One clock edge with the given tick pulses; model advances with the DUT.
  task automatic step(input logic st, input logic lt);
    int L;
    int f;
    step_tick   = st;
    length_tick = lt;
    L = int'(NR11[5:0]);
    f = {internal_NR14_reg[2:0], internal_NR13_reg};
    if (m_armed != 0 && NR14[7] && m_prev7 == 0) begin
      m_on = 1; m_ticks = 0; m_P = 2048 - f; m_len = 64 - L;
    end else begin
      if (st) m_ticks++;
      if (L != m_prevL && !(lt && NR14[6] && m_len == 1)) begin
        m_len = 64 - L;
      end else if (lt && NR14[6] && m_len != 0) begin
        m_len--;
        if (m_len == 0) m_on = 0;
      end
      if (!enable_square_wave) m_on = 0;
    end
    m_prev7 = int'(NR14[7]);
    m_prevL = L;
    m_armed = 1;
    @(posedge clock);
    #1;
    step_tick   = 1'b0;
    length_tick = 1'b0;
    chk("channel_on", 32'(channel_on), 32'(m_on));
    chk("wave_out", 32'(wave_out), 32'(exp_wave()));
  endtask

  task automatic trig(input logic len_en);
    NR14 = {1'b0, len_en, 6'b0};
    step(1'b0, 1'b0);
    NR14 = {1'b1, len_en, 6'b0};
    step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; step_tick = 1'b0; length_tick = 1'b0;
    NR11 = '0; NR14 = '0; enable_square_wave = 1'b1;
    set_freq(0);
    model_reset();
    #1;
    chk("reset_wave", 32'(wave_out), 32'd0);
    chk("reset_on", 32'(channel_on), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("reset_period", 32'(dut.period_cnt_q), 32'd0);
    chk("reset_duty", 32'(dut.duty_pos_q), 32'd0);
    chk("reset_len", 32'(dut.u_len.cnt_q), 32'd0);

    // Fastest frequency, duty 10: sequencer advances every step tick.
    set_freq(11'h7FF);
    NR11 = {2'b10, 6'd0};
    trig(1'b0);
    chk("trig_on", 32'(channel_on), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("f7ff_wave", 32'(wave_out), 32'(seq10[k % 8]));
      chk("f7ff_pos", 32'(dut.duty_pos_q), 32'(k % 8));
      step(1'b1, 1'b0);
    end

    // freq 0x7FC, duty 00: four ticks per sequencer step.
    set_freq(11'h7FC);
    NR11 = {2'b00, 6'd0};
    trig(1'b0);
    for (int k = 0; k < 16; k++) begin
      chk("f7fc_pos", 32'(dut.duty_pos_q), 32'((k / 4) % 8));
      chk("f7fc_wave", 32'(wave_out), 32'(((k / 4) % 8) == 0));
      step(1'b1, 1'b0);
    end

    // Length expiry with NR11[5:0]=62.
    NR11 = {2'b11, 6'd62};
    trig(1'b1);
    step(1'b0, 1'b1);
    chk("len_tick1_on", 32'(channel_on), 32'd1);
    step(1'b0, 1'b1);
    chk("len_tick2_on", 32'(channel_on), 32'd0);
    step(1'b1, 1'b0);
    chk("len_after_wave", 32'(wave_out), 32'd0);
    trig(1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    chk("len_disabled_on", 32'(channel_on), 32'd1);

    // Sweep overflow kills the channel until the next trigger.
    enable_square_wave = 1'b0;
    step(1'b1, 1'b0);
    enable_square_wave = 1'b1;
    chk("disable_on", 32'(channel_on), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk("disable_sticky", 32'(channel_on), 32'd0);
    trig(1'b0);
    chk("retrig_on", 32'(channel_on), 32'd1);
    chk("retrig_pos", 32'(dut.duty_pos_q), 32'd0);

    // Trigger coincident with both ticks: loads win, ticks dropped.
    NR11 = {2'b01, 6'd10};
    NR14 = 8'h40;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
    NR14 = 8'hC0;
    step(1'b1, 1'b1);
    chk("coinc_period", 32'(dut.period_cnt_q), 32'h7FC);
    chk("coinc_len", 32'(dut.u_len.cnt_q), 32'd54);
    chk("coinc_pos", 32'(dut.duty_pos_q), 32'd0);

    // Asynchronous reset mid-waveform with trigger bit held high.
    NR11 = {2'b11, 6'd0};
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_on", 32'(channel_on), 32'd0);
    chk("midreset_wave", 32'(wave_out), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("held_trig_on", 32'(channel_on), 32'd0);
    trig(1'b0);
    chk("pulse_trig_on", 32'(channel_on), 32'd1);

    // Randomized bursts; channel killed before each frequency change.
    for (int b = 0; b < 24; b++) begin
      logic len_en;
      enable_square_wave = 1'b0;
      step(1'b0, 1'b0);
      enable_square_wave = 1'b1;
      set_freq(int'($urandom_range(11'h7FF, 11'h7E8)));
      NR11 = {2'($urandom), 6'($urandom_range(63, 44))};
      len_en = 1'($urandom);
      trig(len_en);
      for (int c = 0; c < 70; c++) begin
        if ($urandom_range(15, 0) == 0) NR11[7:6] = 2'($urandom);
        enable_square_wave = ($urandom_range(79, 0) != 0);
        step(1'($urandom), ($urandom_range(7, 0) == 0));
      end
      enable_square_wave = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
